// File: rtl/ex_div_unit_if.sv
// Request/response bundle of the EX-stage divider: operands and controls in,
// busy/ok handshake and packed {remainder, quotient} result out.
interface ex_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     dividend_i;
    logic [WIDTH-1:0]     divisor_i;
    logic                 annul_i;
    logic                 busy_o;
    logic                 ok_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_zero_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i, annul_i,
        input  busy_o, ok_o, result_o, div_zero_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, annul_i,
        output busy_o, ok_o, result_o, div_zero_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle restoring radix-2 integer divider (signed/unsigned) for the EX stage.
// One quotient bit per cycle; sign fix-up is applied as the result is committed.
module ex_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ex_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [WIDTH-1:0]      quo_r;
    logic [WIDTH-1:0]      dvs_r;
    logic [WIDTH-1:0]      rem_r;
    logic                  neg_q_r;
    logic                  neg_r_r;
    logic [2*WIDTH-1:0]    result_r;
    logic                  dz_r;

    logic                  last_step_s;
    logic                  divisor_zero_s;
    logic [WIDTH:0]        rem_shift_s;
    logic [WIDTH:0]        diff_s;
    logic                  q_bit_s;
    logic [WIDTH-1:0]      rem_step_s;
    logic [WIDTH-1:0]      quo_step_s;
    logic [WIDTH-1:0]      quo_fix_s;
    logic [WIDTH-1:0]      rem_fix_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    assign last_step_s    = (cnt_r == CNT_W'(WIDTH - 1));
    assign divisor_zero_s = (bus.divisor_i == {WIDTH{1'b0}});

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; annul pulls every state back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.annul_i) begin
                    state_nxt_s = IDLE;
                end else if (bus.start_i) begin
                    state_nxt_s = divisor_zero_s ? DZERO : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (bus.annul_i) begin
                    state_nxt_s = IDLE;
                end else if (last_step_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DZERO: begin
                if (bus.annul_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, keep the trial difference if it did not borrow
    always_comb begin
        rem_shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        q_bit_s     = ~diff_s[WIDTH];
        if (q_bit_s) begin
            rem_step_s = diff_s[WIDTH-1:0];
        end else begin
            rem_step_s = rem_shift_s[WIDTH-1:0];
        end
        quo_step_s = {quo_r[WIDTH-2:0], q_bit_s};
        if (neg_q_r) begin
            quo_fix_s = -quo_step_s;
        end else begin
            quo_fix_s = quo_step_s;
        end
        if (neg_r_r) begin
            rem_fix_s = -rem_step_s;
        end else begin
            rem_fix_s = rem_step_s;
        end
    end

    // Operand latch, iteration datapath and result commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r    <= {CNT_W{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
            dz_r     <= 1'b0;
        end else begin
            dz_r <= (state_r == DZERO) && !bus.annul_i;
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (bus.start_i && !bus.annul_i) begin
                        rem_r   <= {WIDTH{1'b0}};
                        dvs_r   <= magnitude(bus.divisor_i, bus.signed_i);
                        neg_q_r <= bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
                        neg_r_r <= bus.signed_i & bus.dividend_i[WIDTH-1];
                        // Divide-by-zero returns the raw dividend as remainder
                        if (divisor_zero_s) begin
                            quo_r <= bus.dividend_i;
                        end else begin
                            quo_r <= magnitude(bus.dividend_i, bus.signed_i);
                        end
                    end
                end
                RUN: begin
                    if (bus.annul_i) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                        quo_r <= quo_step_s;
                        rem_r <= rem_step_s;
                        if (last_step_s) begin
                            result_r <= {rem_fix_s, quo_fix_s};
                        end
                    end
                end
                DZERO: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (!bus.annul_i) begin
                        result_r <= {quo_r, {WIDTH{1'b1}}};
                    end
                end
                DONE: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy_o     = (state_r == RUN) || (state_r == DONE);
    assign bus.ok_o       = (state_r == DONE);
    assign bus.result_o   = result_r;
    assign bus.div_zero_o = dz_r;
endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: WIDTH=32 and WIDTH=8 instances, directed
// corner cases plus randomized operands checked against an arithmetic model.
module tb_ex_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_div_unit_if #(.WIDTH(32)) bus32 ();
    ex_div_unit_if #(.WIDTH(8))  bus8 ();

    ex_div_unit #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32.slave));
    ex_div_unit #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8.slave));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t        sb32[$];
    exp_t        sb8[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last32   = 64'd0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division on sign-extended 64-bit values
    function automatic exp_t model(input int w, input bit sgn, input logic [31:0] a_in, input logic [31:0] b_in);
        exp_t        e;
        logic [31:0] mask, a, b;
        longint      la, lb, lq, lr;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (b == 32'd0) begin
            e.q = mask; e.r = a; e.dz = 1'b1;
        end else begin
            la = longint'(a);
            lb = longint'(b);
            if (sgn && a[w-1]) la = la - (longint'(1) << w);
            if (sgn && b[w-1]) lb = lb - (longint'(1) << w);
            lq = la / lb;
            lr = la % lb;
            e.q = lq[31:0] & mask;
            e.r = lr[31:0] & mask;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [63:0] pack(input int w, input exp_t e);
        if (w == 32) return {e.r, e.q};
        return {48'd0, e.r[7:0], e.q[7:0]};
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 32) ? bus32.busy_o : bus8.busy_o;
    endfunction

    function automatic logic ok_of(input int w);
        return (w == 32) ? bus32.ok_o : bus8.ok_o;
    endfunction

    function automatic logic dz_of(input int w);
        return (w == 32) ? bus32.div_zero_o : bus8.div_zero_o;
    endfunction

    function automatic logic [63:0] result_of(input int w);
        return (w == 32) ? bus32.result_o : {48'd0, bus8.result_o};
    endfunction

    task automatic drive(input int w, input logic st, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic an);
        if (w == 32) begin
            bus32.start_i = st; bus32.signed_i = sg; bus32.dividend_i = a;
            bus32.divisor_i = b; bus32.annul_i = an;
        end else begin
            bus8.start_i = st; bus8.signed_i = sg; bus8.dividend_i = a[7:0];
            bus8.divisor_i = b[7:0]; bus8.annul_i = an;
        end
    endtask

    // Monitors: pop the scoreboard whenever a DUT presents ok
    always @(negedge clk) begin : mon32
        exp_t e;
        if (bus32.ok_o === 1'b1) begin
            if (sb32.size() == 0) begin
                check("ok32_unexpected", {63'd0, bus32.ok_o}, 64'd0);
            end else begin
                e = sb32.pop_front();
                check("result32", bus32.result_o, pack(32, e));
                check("div_zero32", {63'd0, bus32.div_zero_o}, {63'd0, e.dz});
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (bus8.ok_o === 1'b1) begin
            if (sb8.size() == 0) begin
                check("ok8_unexpected", {63'd0, bus8.ok_o}, 64'd0);
            end else begin
                e = sb8.pop_front();
                check("result8", {48'd0, bus8.result_o}, pack(8, e));
                check("div_zero8", {63'd0, bus8.div_zero_o}, {63'd0, e.dz});
            end
        end
    end

    // kind: 0 normal, 1 annul at abort_at, 2 reset at abort_at, 3 annul during DONE
    task automatic run_op(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input int kind, input bit repulse);
        exp_t e;
        int   lat, first_ok, limit, k;
        bit   busy_ok;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy_of(w) !== 1'b0 && k < 200);
        check("idle_before_start", {63'd0, busy_of(w)}, 64'd0);
        e = model(w, sgn, a, b);
        lat = e.dz ? 2 : w + 1;
        drive(w, 1'b1, sgn, a, b, 1'b0);
        if (kind == 0 || kind == 3) begin
            if (w == 32) begin
                sb32.push_back(e);
                last32 = pack(32, e);
            end else begin
                sb8.push_back(e);
            end
        end
        first_ok = 0;
        busy_ok  = 1'b1;
        limit    = (kind == 1 || kind == 2) ? 40 : lat + 2;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (ok_of(w) === 1'b1 && first_ok == 0) first_ok = n;
            if (kind == 0 && n <= lat + 1)
                busy_ok &= (busy_of(w) === ((n <= lat) && !(n == 1 && e.dz)));
            if (kind == 1 && n == abort_at + 1) begin
                check("annul_busy", {63'd0, busy_of(w)}, 64'd0);
                check("annul_result_hold", result_of(w), last32);
            end
            if (kind == 2 && n == abort_at + 1) begin
                check("reset_result", result_of(w), 64'd0);
                check("reset_flags", {61'd0, busy_of(w), ok_of(w), dz_of(w)}, 64'd0);
            end
            if (kind == 3 && n == lat + 1)
                check("annul_done_idle", {62'd0, busy_of(w), ok_of(w)}, 64'd0);
            if (n == 1) drive(w, 1'b0, sgn, a, b, 1'b0);
            if (repulse && n == 5) drive(w, 1'b1, ~sgn, a ^ 32'h0000_0055, b + 32'd3, 1'b0);
            if (repulse && n == 6) drive(w, 1'b0, sgn, a, b, 1'b0);
            if (kind == 1 && n == abort_at)     drive(w, 1'b0, sgn, a, b, 1'b1);
            if (kind == 1 && n == abort_at + 1) drive(w, 1'b0, sgn, a, b, 1'b0);
            if (kind == 2 && n == abort_at)     rst = 1'b1;
            if (kind == 2 && n == abort_at + 1) rst = 1'b0;
            if (kind == 3 && n == lat)          drive(w, 1'b0, sgn, a, b, 1'b1);
            if (kind == 3 && n == lat + 1)      drive(w, 1'b0, sgn, a, b, 1'b0);
        end
        if (kind == 1 || kind == 2) begin
            check("no_ok_after_abort", 64'(first_ok), 64'd0);
        end else begin
            check("latency", 64'(first_ok), 64'(lat));
            if (kind == 0) check("busy_window", {63'd0, busy_ok}, 64'd1);
        end
        if (kind == 2) last32 = 64'd0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] a, b;
        bit          sgn;
        rst = 1'b1;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(8,  1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset32_result", bus32.result_o, 64'd0);
        check("reset32_flags", {61'd0, bus32.busy_o, bus32.ok_o, bus32.div_zero_o}, 64'd0);
        check("reset8_flags", {61'd0, bus8.busy_o, bus8.ok_o, bus8.div_zero_o}, 64'd0);
        rst = 1'b0;

        run_op(32, 1'b0, 32'd100, 32'd7, 0, 0, 1'b0);
        run_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
        run_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 1'b0);
        run_op(32, 1'b0, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
        run_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op(32, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op(32, 1'b1, 32'h8000_0001, 32'd0, 0, 0, 1'b0);
        run_op(32, 1'b0, 32'd100, 32'd7, 10, 1, 1'b0);
        run_op(32, 1'b0, 32'd100, 32'd7, 10, 2, 1'b0);
        run_op(32, 1'b0, 32'd100, 32'd7, 0, 0, 1'b1);
        run_op(32, 1'b1, 32'hFFFF_FF00, 32'd9, 0, 3, 1'b0);

        // annul beats start in IDLE
        @(negedge clk);
        drive(32, 1'b1, 1'b0, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        check("annul_start_busy", {63'd0, bus32.busy_o}, 64'd0);
        drive(32, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);

        run_op(8, 1'b0, 32'd200, 32'd3, 0, 0, 1'b0);
        run_op(8, 1'b1, 32'h80, 32'hFF, 0, 0, 1'b0);
        run_op(8, 1'b1, 32'hF9, 32'h02, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(32, sgn, a, b, 0, 0, 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 255);
            b = (i % 6 == 0) ? 32'd0 : $urandom_range(0, 255);
            run_op(8, sgn, a, b, 0, 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb32.size() + sb8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Parametrised multi-cycle integer divider for the execute stage; the next generation of the single-width divide path inside the EX ALU.
- Supports signed and unsigned divide with configurable operand width, divide-by-zero flagging and pipeline annul (flush on exception or branch).
- Drives a busy/ok handshake. The EX stage stalls the upstream stages while busy_o is high and consumes the result in the cycle ok_o pulses.
- Result is packed {remainder, quotient} to match the double-register HI/LO write path.

Parameters:
- WIDTH, 32, operand width in bits (≥4). Result bus width is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  request a divide; sampled only in IDLE
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
- dividend_i  in  WIDTH  dividend; sampled with start_i
- divisor_i  in  WIDTH  divisor; sampled with start_i
- annul_i  in  1  abort the current operation; no result is produced
- busy_o  out  1  high in RUN and DONE states
- ok_o  out  1  one-cycle pulse; result_o is valid in that cycle
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
- div_zero_o  out  1  valid while ok_o is high; 1 = divisor was zero

Behaviour:
- Reset: state=IDLE, ok_o=0, busy_o=0, div_zero_o=0, result_o=0, counter=0. Reset mid-operation discards all work; no ok_o is produced.
- FSM states:
  - IDLE: if start_i=1 and annul_i=0, latch the operands.
    - If divisor==0: go to DZERO.
    - Otherwise: go to RUN with counter=0.
    - Latched operands are |dividend| and |divisor| when signed_i=1, raw values otherwise.
    - Also latch neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend); both are 0 if unsigned.
  - RUN: restoring radix-2 step per cycle, shifting one quotient bit in MSB-first, using a (WIDTH+1)-bit partial remainder with trial subtraction.
    - counter increments each cycle.
    - After WIDTH RUN cycles (counter==WIDTH-1 at the edge), go to DONE.
  - DZERO: single cycle, then go to DONE. quotient = all ones, remainder = original dividend (raw, no sign fixup), div_zero flag set.
  - DONE: ok_o=1 for exactly this cycle; result_o and div_zero_o valid; next state is IDLE.
- Post-fixup in DONE for signed operations: quotient is negated if neg_q, remainder is negated if neg_r. Remainder takes the sign of the dividend (MIPS semantics).
- Overflow case (signed, most-negative / -1): quotient = most-negative value (wraps), remainder = 0, div_zero_o=0. No exception is raised here.
- Latency: start accepted at edge t → ok_o high in cycle t+WIDTH+1 (WIDTH RUN cycles + DONE). For divide-by-zero, ok_o is high in cycle t+2.
- result_o holds its last value after DONE until the next DONE. ok_o and div_zero_o are 0 outside DONE.
- start_i while busy_o=1 is ignored; operands are not re-sampled.
- annul_i=1 in any state: next state IDLE, counter cleared, ok_o stays 0 in the following cycle, result_o is unchanged.
  - annul_i and start_i both high in IDLE: annul wins and nothing starts.
  - annul_i during DONE: ok_o is still 1 in that cycle (already committed), and the FSM returns to IDLE.
- Back-to-back: start_i high in the cycle after DONE (state IDLE) is accepted normally. This gives a minimum spacing of WIDTH+2 cycles between starts.
- All outputs are registered or decoded from the registered state only; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=32, unsigned 100/7, start at t → busy_o high t+1..t+33, ok_o only at t+33, result_o={32'd2, 32'd14}, div_zero_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0, dividend 0x12345678, unsigned → ok_o at t+2, quotient 0xFFFFFFFF, remainder 0x12345678, div_zero_o=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, div_zero_o=0. Unsigned same operands → quotient 0, remainder 0x80000000.
- Start 100/7, annul_i at t+10 → busy_o low from t+11, no ok_o through t+40. Same with rst_i at t+10 → all outputs 0 next cycle. start_i re-pulsed at t+5 while busy → ignored, result still {2,14}.
- WIDTH=8 instance, unsigned 200/3 → ok_o at t+9, result_o={8'd2, 8'd66}. Signed -128/-1 → quotient 0x80, remainder 0.
